// File: rtl/dragon_body.sv
// dragon_body: turns the dragon head's per-move grid position/direction into a
// chain of body segments. Each head move pushes the head's previous position
// into slot 0 and ripples every slot back by one, so slot i lags the head by
// i+1 moves. An active-length counter (grow/shrink requests) selects how many
// slots are visible, and two collision flags are produced.
//
// Ports:
//   clk, reset      - clock; synchronous active-low reset
//   move_tick       - head_pos/head_dir valid this cycle (once per move period)
//   head_pos/dir    - head grid position {x[7:4], y[3:0]} and direction
//   grow, shrink    - one-cycle length change requests
//   player_pos      - player grid position
//   segment_pos/dir - packed slot history, slot 0 directly behind the head
//   segment_active  - bit i set when slot i is part of the visible body
//   length          - active segment count
//   body_hit        - registered: player sits on an active segment
//   self_hit        - one-cycle pulse: head moved onto its own body
module dragon_body #(
  parameter int MAX_SEGMENTS = 8,
  parameter int INIT_LENGTH  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      move_tick,
  input  logic [7:0]                head_pos,
  input  logic [1:0]                head_dir,
  input  logic                      grow,
  input  logic                      shrink,
  input  logic [7:0]                player_pos,
  output logic [8*MAX_SEGMENTS-1:0] segment_pos,
  output logic [2*MAX_SEGMENTS-1:0] segment_dir,
  output logic [MAX_SEGMENTS-1:0]   segment_active,
  output logic [3:0]                length,
  output logic                      body_hit,
  output logic                      self_hit
);

  localparam int unsigned NSEG     = MAX_SEGMENTS;
  localparam logic [3:0]  LEN_MAX  = 4'(MAX_SEGMENTS);
  localparam logic [3:0]  LEN_INIT = 4'(INIT_LENGTH);

  logic [7:0] seg_pos_q [NSEG];
  logic [1:0] seg_dir_q [NSEG];
  logic [7:0] last_pos;
  logic [1:0] last_dir;
  logic [1:0] pending_grow;

  logic       shift;
  logic       grow_req;
  logic       shrink_req;
  logic       consume;
  logic [3:0] len_grown;
  logic [3:0] len_next;
  logic [1:0] pend_after;
  logic [1:0] pend_next;
  logic       hit_self;
  logic       hit_body;

  always_comb begin
    shift      = move_tick && (head_pos != last_pos);
    // Simultaneous grow and shrink cancel before either is recorded.
    grow_req   = grow && !shrink;
    shrink_req = shrink && !grow;
    consume    = shift && (pending_grow != 2'd0) && (length < LEN_MAX);

    // Shrink is applied after any grow consumed on the same edge, so the
    // pair nets to zero and the floor of 1 is checked on the grown value.
    len_grown = consume ? length + 4'd1 : length;
    len_next  = (shrink_req && (len_grown > 4'd1)) ? len_grown - 4'd1 : len_grown;

    if (shift && (pending_grow != 2'd0))
      pend_after = (length < LEN_MAX) ? pending_grow - 2'd1 : 2'd0;
    else
      pend_after = pending_grow;
    pend_next = (grow_req && (pend_after != 2'd3)) ? pend_after + 2'd1 : pend_after;

    // The tail slot vacates on a plain move, so it only counts as a hit
    // when this move also grows the body.
    hit_self = 1'b0;
    hit_body = 1'b0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      if (shift && (seg_pos_q[i] == head_pos) &&
          (((4'(i) + 4'd1) < length) || (consume && ((4'(i) + 4'd1) == length))))
        hit_self = 1'b1;
      if ((4'(i) < length) && (seg_pos_q[i] == player_pos))
        hit_body = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NSEG; i++) begin
        seg_pos_q[i] <= '0;
        seg_dir_q[i] <= '0;
      end
      last_pos     <= '0;
      last_dir     <= '0;
      length       <= LEN_INIT;
      pending_grow <= '0;
      body_hit     <= 1'b0;
      self_hit     <= 1'b0;
    end else begin
      if (shift) begin
        // Every slot shifts regardless of length so inactive slots keep real
        // trailing history for segments that appear on a later grow.
        seg_pos_q[0] <= last_pos;
        seg_dir_q[0] <= last_dir;
        for (int unsigned i = 1; i < NSEG; i++) begin
          seg_pos_q[i] <= seg_pos_q[i-1];
          seg_dir_q[i] <= seg_dir_q[i-1];
        end
        last_pos <= head_pos;
        last_dir <= head_dir;
      end
      length       <= len_next;
      pending_grow <= pend_next;
      body_hit     <= hit_body;
      self_hit     <= hit_self;
    end
  end

  always_comb begin
    segment_pos    = '0;
    segment_dir    = '0;
    segment_active = '0;
    for (int unsigned i = 0; i < NSEG; i++) begin
      segment_pos[8*i +: 8] = seg_pos_q[i];
      segment_dir[2*i +: 2] = seg_dir_q[i];
      segment_active[i]     = (4'(i) < length);
    end
  end

endmodule

// File: tb/tb_dragon_body.sv
module tb_dragon_body;

  localparam int MAXS = 8;
  localparam int INIT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            move_tick = 1'b0;
  logic [7:0]      head_pos = '0;
  logic [1:0]      head_dir = '0;
  logic            grow = 1'b0;
  logic            shrink = 1'b0;
  logic [7:0]      player_pos = 8'hFF;
  logic [8*MAXS-1:0] segment_pos;
  logic [2*MAXS-1:0] segment_dir;
  logic [MAXS-1:0]   segment_active;
  logic [3:0]        length;
  logic              body_hit;
  logic              self_hit;

  int errors = 0;
  int checks = 0;

  dragon_body #(.MAX_SEGMENTS(MAXS), .INIT_LENGTH(INIT)) dut (
    .clk(clk), .reset(reset), .move_tick(move_tick), .head_pos(head_pos),
    .head_dir(head_dir), .grow(grow), .shrink(shrink), .player_pos(player_pos),
    .segment_pos(segment_pos), .segment_dir(segment_dir),
    .segment_active(segment_active), .length(length),
    .body_hit(body_hit), .self_hit(self_hit)
  );

  always #5 clk = ~clk;

  // Reference model: a history queue (front = slot 0) plus the head's
  // last sampled position, length and outstanding grow count.
  logic [9:0] m_hist[$];       // {dir, pos}
  logic [7:0] m_last;
  logic [1:0] m_ldir;
  int         m_len;
  int         m_pend;
  bit         m_body;
  bit         m_self;

  task automatic model_update(input logic r, input logic t, input logic [7:0] hp,
                              input logic [1:0] hd, input logic g, input logic s,
                              input logic [7:0] pp);
    bit moved, take, nb, ns;
    int limit;
    if (!r) begin
      m_hist.delete();
      for (int i = 0; i < MAXS; i++) m_hist.push_back(10'd0);
      m_last = 8'h00; m_ldir = 2'd0; m_len = INIT; m_pend = 0;
      m_body = 0; m_self = 0;
      return;
    end
    moved = t && (hp != m_last);
    take  = moved && (m_pend > 0) && (m_len < MAXS);
    nb = 0;
    for (int i = 0; i < m_len; i++) if (m_hist[i][7:0] == pp) nb = 1;
    ns = 0;
    if (moved) begin
      limit = take ? m_len : m_len - 1;
      for (int i = 0; i < limit; i++) if (m_hist[i][7:0] == hp) ns = 1;
      m_hist.push_front({m_ldir, m_last});
      void'(m_hist.pop_back());
      m_last = hp; m_ldir = hd;
      if (m_pend > 0) begin
        if (m_len < MAXS) begin m_len++; m_pend--; end
        else m_pend = 0;
      end
    end
    if (s && !g && m_len > 1) m_len--;
    if (g && !s && m_pend < 3) m_pend++;
    m_body = nb; m_self = ns;
  endtask

  task automatic do_cycle(input logic r, input logic t, input logic [7:0] hp,
                          input logic [1:0] hd, input logic g, input logic s,
                          input logic [7:0] pp);
    reset = r; move_tick = t; head_pos = hp; head_dir = hd;
    grow = g; shrink = s; player_pos = pp;
    @(posedge clk);
    model_update(r, t, hp, hd, g, s, pp);
    #1;
  endtask

  task automatic idle(input logic [7:0] pp);
    do_cycle(1, 0, 8'h00, 2'd0, 0, 0, pp);
  endtask

  task automatic tick(input logic [7:0] hp, input logic [1:0] hd, input logic s);
    do_cycle(1, 1, hp, hd, 0, s, 8'hFF);
  endtask

  task automatic test_reset();
    do_cycle(0, 0, 8'h00, 2'd0, 0, 0, 8'hFF);
    do_cycle(0, 0, 8'h00, 2'd0, 0, 0, 8'hFF);
    checks++; if (length !== 4'd3) begin errors++; $display("FAIL reset_length got=%0d exp=3", length); end
    checks++; if (segment_active !== 8'b0000_0111) begin errors++; $display("FAIL reset_active got=%b exp=00000111", segment_active); end
    checks++; if (segment_pos !== '0) begin errors++; $display("FAIL reset_pos got=%h exp=0", segment_pos); end
    checks++; if (segment_dir !== '0) begin errors++; $display("FAIL reset_dir got=%h exp=0", segment_dir); end
    checks++; if (body_hit !== 1'b0) begin errors++; $display("FAIL reset_body_hit got=%b exp=0", body_hit); end
    checks++; if (self_hit !== 1'b0) begin errors++; $display("FAIL reset_self_hit got=%b exp=0", self_hit); end
  endtask

  task automatic test_shift();
    logic [7:0] hp;
    for (int k = 1; k <= 3; k++) begin
      hp = 8'(k * 16);
      tick(hp, 2'd1, 0);
      checks++; if (self_hit !== 1'b0) begin errors++; $display("FAIL shift_self_hit%0d got=%b exp=0", k, self_hit); end
    end
    checks++; if (segment_pos[7:0] !== 8'h20) begin errors++; $display("FAIL shift_slot0 got=%h exp=20", segment_pos[7:0]); end
    checks++; if (segment_pos[15:8] !== 8'h10) begin errors++; $display("FAIL shift_slot1 got=%h exp=10", segment_pos[15:8]); end
    checks++; if (segment_pos[23:16] !== 8'h00) begin errors++; $display("FAIL shift_slot2 got=%h exp=00", segment_pos[23:16]); end
    checks++; if (segment_dir[1:0] !== 2'b01) begin errors++; $display("FAIL shift_dir0 got=%b exp=01", segment_dir[1:0]); end
    checks++; if (segment_dir[5:4] !== 2'b00) begin errors++; $display("FAIL shift_dir2 got=%b exp=00", segment_dir[5:4]); end
  endtask

  task automatic test_stall();
    tick(8'h30, 2'd2, 0);
    idle(8'hFF);
    checks++; if (segment_pos[23:0] !== 24'h00_10_20) begin errors++; $display("FAIL stall_slots got=%h exp=001020", segment_pos[23:0]); end
    checks++; if (length !== 4'd3) begin errors++; $display("FAIL stall_length got=%0d exp=3", length); end
    checks++; if (self_hit !== 1'b0) begin errors++; $display("FAIL stall_self_hit got=%b exp=0", self_hit); end
  endtask

  task automatic test_grow();
    int exp_len;
    do_cycle(1, 0, 8'h00, 2'd0, 1, 0, 8'hFF);
    checks++; if (length !== 4'd3) begin errors++; $display("FAIL grow_wait_length got=%0d exp=3", length); end
    tick(8'h40, 2'd1, 0);
    checks++; if (length !== 4'd4) begin errors++; $display("FAIL grow_length got=%0d exp=4", length); end
    checks++; if (segment_pos[31:0] !== 32'h00_10_20_30) begin errors++; $display("FAIL grow_slots got=%h exp=00102030", segment_pos[31:0]); end
    for (int k = 5; k <= 10; k++) begin
      do_cycle(1, 0, 8'h00, 2'd0, 1, 0, 8'hFF);
      tick(8'(k * 16), 2'd1, 0);
      exp_len = (k < MAXS) ? k : MAXS;
      checks++; if (length !== 4'(exp_len)) begin errors++; $display("FAIL grow_sat_length%0d got=%0d exp=%0d", k, length, exp_len); end
    end
    checks++; if (segment_active !== 8'hFF) begin errors++; $display("FAIL grow_active got=%b exp=11111111", segment_active); end
    // pending grow must have been discarded at full length
    do_cycle(1, 0, 8'h00, 2'd0, 0, 1, 8'hFF);
    tick(8'hB0, 2'd1, 0);
    checks++; if (length !== 4'd7) begin errors++; $display("FAIL grow_cleared_length got=%0d exp=7", length); end
    checks++; if (segment_pos[7:0] !== 8'hA0) begin errors++; $display("FAIL grow_slot0 got=%h exp=a0", segment_pos[7:0]); end
  endtask

  task automatic test_cancel();
    do_cycle(1, 0, 8'h00, 2'd0, 1, 1, 8'hFF);
    checks++; if (length !== 4'd7) begin errors++; $display("FAIL cancel_length got=%0d exp=7", length); end
    tick(8'hC0, 2'd1, 0);
    checks++; if (length !== 4'd7) begin errors++; $display("FAIL cancel_nogrow got=%0d exp=7", length); end
    do_cycle(1, 0, 8'h00, 2'd0, 1, 0, 8'hFF);
    tick(8'hD0, 2'd1, 1);
    checks++; if (length !== 4'd7) begin errors++; $display("FAIL grow_shrink_net got=%0d exp=7", length); end
    do_cycle(0, 0, 8'h00, 2'd0, 0, 0, 8'hFF);
    for (int k = 1; k <= 5; k++) begin
      do_cycle(1, 0, 8'h00, 2'd0, 0, 1, 8'hFF);
      checks++; if (length !== 4'((k < 2) ? 3 - k : 1)) begin errors++; $display("FAIL shrink_length%0d got=%0d exp=%0d", k, length, (k < 2) ? 3 - k : 1); end
    end
    checks++; if (segment_active !== 8'b0000_0001) begin errors++; $display("FAIL shrink_active got=%b exp=00000001", segment_active); end
  endtask

  task automatic test_hits();
    do_cycle(0, 0, 8'h00, 2'd0, 0, 0, 8'hFF);
    tick(8'h12, 2'd0, 0);
    tick(8'h22, 2'd1, 0);
    tick(8'h21, 2'd0, 0);
    tick(8'h20, 2'd0, 0);
    checks++; if (segment_pos[23:0] !== 24'h12_22_21) begin errors++; $display("FAIL hit_slots got=%h exp=122221", segment_pos[23:0]); end
    idle(8'hFF);
    checks++; if (body_hit !== 1'b0) begin errors++; $display("FAIL body_hit_before got=%b exp=0", body_hit); end
    idle(8'h22);
    checks++; if (body_hit !== 1'b1) begin errors++; $display("FAIL body_hit_after got=%b exp=1", body_hit); end
    do_cycle(1, 1, 8'h21, 2'd3, 0, 0, 8'h22);
    checks++; if (self_hit !== 1'b1) begin errors++; $display("FAIL self_hit_pulse got=%b exp=1", self_hit); end
    idle(8'h22);
    checks++; if (self_hit !== 1'b0) begin errors++; $display("FAIL self_hit_clear got=%b exp=0", self_hit); end
    checks++; if (body_hit !== 1'b1) begin errors++; $display("FAIL body_hit_hold got=%b exp=1", body_hit); end
    // slots 0x20,0x21,0x22: moving onto the vacating tail is not a hit
    tick(8'h22, 2'd1, 0);
    checks++; if (self_hit !== 1'b0) begin errors++; $display("FAIL self_hit_tail got=%b exp=0", self_hit); end
    tick(8'h23, 2'd0, 0);
    do_cycle(1, 0, 8'h00, 2'd0, 1, 0, 8'hFF);
    // slots 0x22,0x21,0x20 with a pending grow: the tail stays put
    tick(8'h20, 2'd2, 0);
    checks++; if (self_hit !== 1'b1) begin errors++; $display("FAIL self_hit_grow_tail got=%b exp=1", self_hit); end
    checks++; if (length !== 4'd4) begin errors++; $display("FAIL hit_grow_length got=%0d exp=4", length); end
  endtask

  task automatic test_random();
    logic [8*MAXS-1:0] exp_pos;
    logic [2*MAXS-1:0] exp_dir;
    logic [MAXS-1:0]   exp_act;
    logic r, t, g, s;
    logic [7:0] hp, pp;
    do_cycle(0, 0, 8'h00, 2'd0, 0, 0, 8'hFF);
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(0, 99) != 0);
      t  = ($urandom_range(0, 2) == 0);
      g  = ($urandom_range(0, 5) == 0);
      s  = ($urandom_range(0, 7) == 0);
      hp = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      pp = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      do_cycle(r, t, hp, 2'($urandom), g, s, pp);
      for (int i = 0; i < MAXS; i++) begin
        exp_pos[8*i +: 8] = m_hist[i][7:0];
        exp_dir[2*i +: 2] = m_hist[i][9:8];
        exp_act[i]        = (i < m_len);
      end
      checks++; if (length !== 4'(m_len)) begin errors++; $display("FAIL rnd_length n=%0d got=%0d exp=%0d", n, length, m_len); end
      checks++; if (segment_active !== exp_act) begin errors++; $display("FAIL rnd_active n=%0d got=%b exp=%b", n, segment_active, exp_act); end
      checks++; if (segment_pos !== exp_pos) begin errors++; $display("FAIL rnd_pos n=%0d got=%h exp=%h", n, segment_pos, exp_pos); end
      checks++; if (segment_dir !== exp_dir) begin errors++; $display("FAIL rnd_dir n=%0d got=%h exp=%h", n, segment_dir, exp_dir); end
      checks++; if (body_hit !== m_body) begin errors++; $display("FAIL rnd_body_hit n=%0d got=%b exp=%b", n, body_hit, m_body); end
      checks++; if (self_hit !== m_self) begin errors++; $display("FAIL rnd_self_hit n=%0d got=%b exp=%b", n, self_hit, m_self); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_shift();
    test_stall();
    test_grow();
    test_cancel();
    test_hits();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dragon_body.md
Name: dragon_body

Overview:
- Consumer end of the dragon head's position/direction output. Turns the head's stream of grid positions into a chain of body segments, each lagging one head move behind the one in front.
- Keeps a fixed-depth position/direction history, an active-length counter with grow/shrink requests, and collision flags against the player and against the head itself.
- Sits between the dragon head and the sprite renderer/game-state logic.

Parameters:
- MAX_SEGMENTS, 8, number of history slots and maximum body length (2..15).
- INIT_LENGTH, 3, active length after reset (1..MAX_SEGMENTS).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low; clock clk.
- move_tick  input  1  one-cycle pulse; head position/direction are valid to sample (once per movement period).
- head_pos  input  8  head grid position {x[7:4], y[3:0]}.
- head_dir  input  2  head direction: 00 up, 01 right, 10 down, 11 left.
- grow  input  1  one-cycle pulse requesting one extra segment.
- shrink  input  1  one-cycle pulse requesting removal of one segment.
- player_pos  input  8  player grid position {x, y}.
- segment_pos  output  8*MAX_SEGMENTS  slot i at bits [8i+7:8i]; slot 0 is directly behind the head.
- segment_dir  output  2*MAX_SEGMENTS  slot i at bits [2i+1:2i].
- segment_active  output  MAX_SEGMENTS  bit i = (i < length).
- length  output  4  current active segment count.
- body_hit  output  1  registered: player_pos equals an active segment position.
- self_hit  output  1  one-cycle pulse: head moved onto an active segment.

Behaviour:
- Reset (reset==0 at a clk edge):
  - all segment_pos = 0 and segment_dir = 0;
  - last_pos = 0, last_dir = 0;
  - length = INIT_LENGTH;
  - pending_grow = 0;
  - body_hit = 0, self_hit = 0.
  - Reset asserted mid-operation discards all history and pending requests on that edge.
- Move detection: a shift occurs only on a cycle with move_tick==1 AND head_pos != last_pos. A tick with an unchanged head_pos (head stopped next to the player) causes no shift, no length change and no self_hit.
- Shift, applied at the edge ending the tick cycle (outputs valid the next cycle):
  - slot 0 <= {last_pos, last_dir};
  - slot i <= slot i-1 for i = 1..MAX_SEGMENTS-1;
  - last_pos <= head_pos, last_dir <= head_dir.
  - All slots shift regardless of length, so inactive slots carry true trailing history and a newly grown segment appears at a real previous position.
- Grow:
  - grow increments pending_grow, 2-bit, saturating at 3.
  - On each shift with pending_grow>0 and length<MAX_SEGMENTS: length += 1, pending_grow -= 1.
  - At MAX_SEGMENTS, pending_grow is cleared on the shift and length is unchanged.
- Shrink: applied on the edge after the pulse, independent of shifts. length -= 1 if length > 1; length never drops below 1.
- Simultaneous events:
  - grow and shrink in the same cycle cancel: neither is recorded.
  - A shrink coinciding with a shift that consumes a pending grow yields a net length change of 0.
- self_hit, evaluated on shift cycles against pre-shift state:
  - Pulses 1 if head_pos equals slot i position for some i < length-1.
  - Slot length-1 is also checked if the same shift consumes a pending grow, because in that case the tail does not vacate.
  - Clears after one cycle.
- body_hit:
  - Recomputed every cycle from registered state as OR over i<length of (segment_pos[i]==player_pos).
  - One cycle latency from a player_pos change or a segment change.
- Arithmetic: all compares are full 8-bit equality. No wrap on grid coordinates, because positions are copied and never computed.

Test Plan:
- Reset with INIT_LENGTH=3 -> length=3, segment_active=8'b0000_0111, all segment_pos=0, body_hit=0, self_hit=0.
- Head 0x00 then ticks at head_pos 0x10, 0x20, 0x30 (dir 01) -> slot0=0x20, slot1=0x10, slot2=0x00, slot0 dir=01, no self_hit.
- Tick with head_pos equal to the previous tick's value -> slot contents and length unchanged, self_hit stays 0.
- grow pulse, then tick -> length 3->4 on that tick and slot3 shows the real prior position. 6 grows plus ticks -> length saturates at 8.
- grow and shrink in the same cycle -> length unchanged. 5 shrink pulses from length 3 -> length stops at 1.
- Segments at 0x21, 0x22, 0x12 (length 3) with player_pos=0x22 -> body_hit=1 one cycle later. Head loops back onto 0x21 via a tick -> self_hit pulses for exactly 1 cycle.
